cpu_bus_arbiter: RTL and testbench
==================================

// Module: cpu_bus_arbiter
// PURPOSE
//  Sits directly downstream of the multi-cycle CPU core. Merges its instruction-fetch
//  request port and data-access request port onto one shared memory request bus.
//  Only one transaction is outstanding at a time. Each response is routed back to its originator.
//  A watchdog aborts a transaction that hangs and reports the abort through a sticky error flag.
// PARAMETERS
//  TIMEOUT  256  max cycles in S_REQ+S_WAIT before abort; 0 disables watchdog
//  CNT_W    9    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   synchronous, active-high reset
//  i_valid      in   1   instruction request valid (read, 4 bytes)
//  i_addr       in   32  instruction address
//  i_addr_ok    out  1   1-cycle pulse: instruction request accepted by memory
//  i_data_ok    out  1   1-cycle pulse: i_data valid
//  i_data       out  32  fetched word
//  d_valid      in   1   data request valid
//  d_write      in   1   1=store, 0=load
//  d_addr       in   32  data address
//  d_size       in   3   log2 byte count (0..2)
//  d_strobe     in   4   byte enables (store only)
//  d_wdata      in   32  store data
//  d_addr_ok    out  1   1-cycle pulse: data request accepted
//  d_data_ok    out  1   1-cycle pulse: d_rdata valid / store complete
//  d_rdata      out  32  load data
//  m_valid      out  1   shared request valid
//  m_write      out  1   shared request is store
//  m_addr       out  32  shared address
//  m_size       out  3   shared size
//  m_strobe     out  4   shared byte enables (0 for reads)
//  m_wdata      out  32  shared store data
//  m_ready      in   1   memory accepts request this cycle when m_valid=1
//  m_rvalid     in   1   memory response valid (single beat)
//  m_rdata      in   32  memory response data
//  err          out  1   sticky: a watchdog abort occurred
// BEHAVIOUR
//  Reset: state=S_IDLE, counter=0, err=0, all m_* outputs=0, all *_ok outputs=0, data outputs=0.
//  The reset request must be held for one clk edge. Reset mid-transaction drops the transaction silently.
//  FSM:
//   S_IDLE: if d_valid | i_valid, latch owner, addr/size/strobe/wdata/write into the request register,
//           then go to S_REQ. Data has priority when both are valid; the instruction request stays pending.
//   S_REQ:  m_valid=1, driven from registers only.
//           On m_ready: pulse owner's *_addr_ok in the same cycle, then go to S_WAIT.
//   S_WAIT: m_valid=0. On m_rvalid: pulse owner's *_data_ok for 1 cycle.
//           In that cycle, *_data is driven from m_rdata, combinationally passed through. Then go to S_IDLE.
//  Latency: req seen at edge N -> m_valid from cycle N+1 (registered).
//   Best case back-to-back: IDLE, REQ+ready, WAIT+rvalid -> 3 cycles per transaction.
//  Request inputs are sampled only in S_IDLE; changes during S_REQ/S_WAIT are ignored.
//   The core must hold *_valid until *_addr_ok.
//  m_rvalid/m_ready in S_IDLE: ignored. m_rvalid in S_REQ: ignored (illegal; no state change).
//  m_strobe is forced to 4'b0000 for reads. Instruction requests use size=2, write=0.
//  Watchdog (TIMEOUT>0): the counter clears on entering S_REQ and increments each cycle in S_REQ/S_WAIT.
//   On reaching TIMEOUT, the block:
//   - pulses owner's *_addr_ok if still in S_REQ;
//   - pulses owner's *_data_ok with data=32'h0;
//   - sets err=1;
//   - goes to S_IDLE.
//   When completion and timeout coincide in the same cycle, the real completion wins and err is not set.
//  At most one *_ok pulse of each kind per cycle. i_* and d_* pulses are never asserted together.
//  Counter saturates and never wraps.
// TESTING
//  1 fetch: i_valid, addr=0xBFC00000; m_ready next cycle; m_rvalid+rdata=0x24080001 one cycle later
//    -> i_addr_ok pulses once; i_data_ok with i_data=0x24080001; d_* stay 0.
//  2 conflict: i_valid and d_valid (load 0x80000010) same cycle -> data served first (m_addr=0x80000010).
//    Then the fetch is served; d_data_ok precedes i_addr_ok.
//  3 store: d_write=1, size=0, strobe=4'b0010, wdata=0x0000AB00
//    -> m_write=1, m_strobe=4'b0010, m_wdata=0x0000AB00 held stable until m_ready.
//  4 backpressure: m_ready low 5 cycles -> m_valid and m_* stable for 5 cycles; no addr_ok until ready.
//  5 timeout (TIMEOUT=8): m_ready=1, m_rvalid never
//    -> d_data_ok with d_rdata=0 at cycle 8 of the transaction; err=1 stays set; next request serviced normally.
//  6 reset in S_WAIT, then m_rvalid -> no *_data_ok; FSM in S_IDLE; err=0; m_valid=0.

Source files
------------

// File: rtl/cpu_bus_arbiter_if.sv
// cpu_bus_arbiter_if
//   Groups every handshake/bus signal of the CPU bus arbiter:
//   - i_*  : instruction-fetch request port (read-only, 4-byte words)
//   - d_*  : data-access request port (loads and stores)
//   - m_*  : shared memory request/response bus
//   Modports:
//   - master : the arbiter's view (takes core requests, drives the memory bus)
//   - slave  : the environment's view (core plus memory)
//
// Handshake rules (one place, applies to all ports):
//   A request on i_valid/d_valid is held by the core until the matching
//   *_addr_ok pulse. The memory accepts a request in a cycle where
//   m_valid=1 and m_ready=1. A response is a single beat in the cycle where
//   m_rvalid=1. *_addr_ok and *_data_ok are single-cycle pulses, and the
//   returned data is valid only in the *_data_ok cycle.
interface cpu_bus_arbiter_if;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_data;

  logic        d_valid;
  logic        d_write;
  logic [31:0] d_addr;
  logic [2:0]  d_size;
  logic [3:0]  d_strobe;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;

  logic        m_valid;
  logic        m_write;
  logic [31:0] m_addr;
  logic [2:0]  m_size;
  logic [3:0]  m_strobe;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  modport master (
    input  i_valid, i_addr,
    output i_addr_ok, i_data_ok, i_data,
    input  d_valid, d_write, d_addr, d_size, d_strobe, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_valid, m_write, m_addr, m_size, m_strobe, m_wdata,
    input  m_ready, m_rvalid, m_rdata
  );

  modport slave (
    output i_valid, i_addr,
    input  i_addr_ok, i_data_ok, i_data,
    output d_valid, d_write, d_addr, d_size, d_strobe, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_valid, m_write, m_addr, m_size, m_strobe, m_wdata,
    output m_ready, m_rvalid, m_rdata
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
//   Merges the CPU core's instruction-fetch and data-access request ports onto
//   one shared memory bus with a single outstanding transaction. Responses are
//   routed back to the port that issued the request. A watchdog aborts a hung
//   transaction and records the abort in a sticky error flag.
// Ports:
//   clk       : clock, all state on posedge
//   reset     : synchronous, active-high reset
//   bus       : cpu_bus_arbiter_if.master (i_*, d_*, m_* signals)
//   err       : sticky watchdog-abort flag
//   state_dbg : current FSM state (0=IDLE, 1=REQ, 2=WAIT)
module cpu_bus_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  cpu_bus_arbiter_if.master        bus,
  output logic                     err,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic             WD_EN    = (TIMEOUT != 0);
  // Value of the counter during the TIMEOUT-th cycle spent in REQ/WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT != 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic             owner_d;   // 1: data port owns the transaction, 0: fetch port
  logic [CNT_W-1:0] cnt;

  logic busy;
  logic timeout;
  logic resp;
  logic addr_ok;
  logic data_ok;

  assign busy    = (state == S_REQ) || (state == S_WAIT);
  // A real response in WAIT wins over a coincident timeout.
  assign resp    = (state == S_WAIT) && bus.m_rvalid;
  assign timeout = WD_EN && busy && (cnt >= CNT_LAST) && !resp;

  // An abort in REQ still pulses addr_ok so the core can drop its request.
  assign addr_ok = (state == S_REQ) && (bus.m_ready || timeout);
  assign data_ok = resp || timeout;

  assign bus.i_addr_ok = addr_ok && !owner_d;
  assign bus.d_addr_ok = addr_ok &&  owner_d;
  assign bus.i_data_ok = data_ok && !owner_d;
  assign bus.d_data_ok = data_ok &&  owner_d;
  // Response data passes straight through; an abort returns zero.
  assign bus.i_data    = (resp && !owner_d) ? bus.m_rdata : 32'h0;
  assign bus.d_rdata   = (resp &&  owner_d) ? bus.m_rdata : 32'h0;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      owner_d      <= 1'b0;
      cnt          <= '0;
      err          <= 1'b0;
      bus.m_valid  <= 1'b0;
      bus.m_write  <= 1'b0;
      bus.m_addr   <= 32'h0;
      bus.m_size   <= 3'd0;
      bus.m_strobe <= 4'h0;
      bus.m_wdata  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.d_valid || bus.i_valid) begin
            state       <= S_REQ;
            cnt         <= '0;
            bus.m_valid <= 1'b1;
            // Data port has priority; a fetch stays pending on i_valid.
            if (bus.d_valid) begin
              owner_d      <= 1'b1;
              bus.m_write  <= bus.d_write;
              bus.m_addr   <= bus.d_addr;
              bus.m_size   <= bus.d_size;
              bus.m_strobe <= bus.d_write ? bus.d_strobe : 4'h0;
              bus.m_wdata  <= bus.d_wdata;
            end else begin
              owner_d      <= 1'b0;
              bus.m_write  <= 1'b0;
              bus.m_addr   <= bus.i_addr;
              bus.m_size   <= 3'd2;
              bus.m_strobe <= 4'h0;
              bus.m_wdata  <= 32'h0;
            end
          end
        end
        S_REQ: begin
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          if (timeout) begin
            state       <= S_IDLE;
            bus.m_valid <= 1'b0;
            err         <= 1'b1;
          end else if (bus.m_ready) begin
            state       <= S_WAIT;
            bus.m_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          if (resp) begin
            state <= S_IDLE;
          end else if (timeout) begin
            state <= S_IDLE;
            err   <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          bus.m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter
//   Directed bench for cpu_bus_arbiter with TIMEOUT=8. Inputs change 1 ns
//   after the rising edge; outputs are checked on the falling edge.
module tb_cpu_bus_arbiter;

  logic       clk;
  logic       reset;
  logic       err;
  logic [1:0] state_dbg;
  int         n_assert;
  int         n_fail;

  cpu_bus_arbiter_if bus ();

  cpu_bus_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_oks(input string tag, input logic [3:0] exp);
    chk(tag, {28'h0, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok}, {28'h0, exp});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.i_valid = 1'b0; bus.i_addr = 32'h0;
    bus.d_valid = 1'b0; bus.d_write = 1'b0; bus.d_addr = 32'h0;
    bus.d_size = 3'd0; bus.d_strobe = 4'h0; bus.d_wdata = 32'h0;
    bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;

    // reset state
    next_cycle(); next_cycle();
    sample();
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_mvalid", 32'(bus.m_valid), 32'd0);
    chk("rst_maddr", bus.m_addr, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk_oks("rst_oks", 4'b0000);
    next_cycle(); reset = 1'b0;

    // 1: fetch
    next_cycle(); bus.i_valid = 1'b1; bus.i_addr = 32'hBFC0_0000;
    sample(); chk_oks("f1_idle_oks", 4'b0000);
    next_cycle(); bus.m_ready = 1'b1;
    sample();
    chk("f1_state_req", 32'(state_dbg), 32'd1);
    chk("f1_mvalid", 32'(bus.m_valid), 32'd1);
    chk("f1_maddr", bus.m_addr, 32'hBFC0_0000);
    chk("f1_msize", 32'(bus.m_size), 32'd2);
    chk("f1_mwrite", 32'(bus.m_write), 32'd0);
    chk_oks("f1_addr_ok", 4'b1000);
    next_cycle(); bus.i_valid = 1'b0; bus.m_ready = 1'b0;
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h2408_0001;
    sample();
    chk("f1_mvalid_wait", 32'(bus.m_valid), 32'd0);
    chk_oks("f1_data_ok", 4'b0100);
    chk("f1_idata", bus.i_data, 32'h2408_0001);
    chk("f1_drdata", bus.d_rdata, 32'h0);
    next_cycle(); bus.m_rvalid = 1'b0;
    sample();
    chk("f1_back_idle", 32'(state_dbg), 32'd0);
    chk_oks("f1_idle_oks2", 4'b0000);

    // 2: conflict, data first
    next_cycle(); bus.i_valid = 1'b1; bus.i_addr = 32'hBFC0_0004;
    bus.d_valid = 1'b1; bus.d_write = 1'b0; bus.d_addr = 32'h8000_0010;
    bus.d_size = 3'd2; bus.d_strobe = 4'hF;
    next_cycle(); bus.m_ready = 1'b1;
    sample();
    chk("c_maddr_d", bus.m_addr, 32'h8000_0010);
    chk("c_mstrobe_rd", 32'(bus.m_strobe), 32'd0);
    chk_oks("c_d_addr_ok", 4'b0010);
    next_cycle(); bus.d_valid = 1'b0; bus.m_ready = 1'b0;
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1234_5678;
    sample();
    chk_oks("c_d_data_ok", 4'b0001);
    chk("c_drdata", bus.d_rdata, 32'h1234_5678);
    chk("c_idata_zero", bus.i_data, 32'h0);
    next_cycle(); bus.m_rvalid = 1'b0;
    sample(); chk_oks("c_idle_oks", 4'b0000);
    next_cycle(); bus.m_ready = 1'b1;
    sample();
    chk("c_maddr_i", bus.m_addr, 32'hBFC0_0004);
    chk_oks("c_i_addr_ok", 4'b1000);
    next_cycle(); bus.i_valid = 1'b0; bus.m_ready = 1'b0;
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h8C09_0000;
    sample();
    chk_oks("c_i_data_ok", 4'b0100);
    chk("c_idata", bus.i_data, 32'h8C09_0000);
    next_cycle(); bus.m_rvalid = 1'b0;

    // 3+4: store under 5 cycles of backpressure
    next_cycle(); bus.d_valid = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h8000_0020;
    bus.d_size = 3'd0; bus.d_strobe = 4'b0010; bus.d_wdata = 32'h0000_AB00;
    next_cycle(); bus.d_wdata = 32'hFFFF_FFFF; bus.d_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("s_mvalid", 32'(bus.m_valid), 32'd1);
      chk("s_mwrite", 32'(bus.m_write), 32'd1);
      chk("s_mstrobe", 32'(bus.m_strobe), 32'b0010);
      chk("s_mwdata", bus.m_wdata, 32'h0000_AB00);
      chk("s_maddr", bus.m_addr, 32'h8000_0020);
      chk("s_msize", 32'(bus.m_size), 32'd0);
      chk_oks("s_no_ok", 4'b0000);
      next_cycle();
    end
    bus.m_ready = 1'b1;
    sample(); chk_oks("s_addr_ok", 4'b0010);
    next_cycle(); bus.d_valid = 1'b0; bus.m_ready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0;
    sample();
    chk_oks("s_data_ok", 4'b0001);
    chk("s_err", 32'(err), 32'd0);
    next_cycle(); bus.m_rvalid = 1'b0; bus.d_write = 1'b0;

    // 5: timeout, memory accepts but never responds
    next_cycle(); bus.d_valid = 1'b1; bus.d_addr = 32'h8000_0030; bus.d_size = 3'd2;
    next_cycle(); bus.m_ready = 1'b1;
    sample(); chk_oks("t_addr_ok", 4'b0010);
    next_cycle(); bus.d_valid = 1'b0; bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk_oks("t_wait_no_ok", 4'b0000);
      next_cycle();
    end
    sample();
    chk_oks("t_abort_ok", 4'b0001);
    chk("t_abort_data", bus.d_rdata, 32'h0);
    chk("t_err_before", 32'(err), 32'd0);
    next_cycle();
    sample();
    chk("t_err_set", 32'(err), 32'd1);
    chk("t_idle", 32'(state_dbg), 32'd0);
    next_cycle(); bus.i_valid = 1'b1; bus.i_addr = 32'hBFC0_0008;
    next_cycle(); bus.m_ready = 1'b1;
    sample(); chk_oks("t_next_addr_ok", 4'b1000);
    next_cycle(); bus.i_valid = 1'b0; bus.m_ready = 1'b0;
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFE_0001;
    sample();
    chk("t_next_idata", bus.i_data, 32'hCAFE_0001);
    chk("t_err_sticky", 32'(err), 32'd1);
    next_cycle(); bus.m_rvalid = 1'b0;

    // 6: reset while waiting for a response
    next_cycle(); bus.i_valid = 1'b1; bus.i_addr = 32'hBFC0_0010;
    next_cycle(); bus.m_ready = 1'b1;
    next_cycle(); bus.i_valid = 1'b0; bus.m_ready = 1'b0; reset = 1'b1;
    sample(); chk("r_in_wait", 32'(state_dbg), 32'd2);
    next_cycle(); reset = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
    sample();
    chk_oks("r_no_data_ok", 4'b0000);
    chk("r_state", 32'(state_dbg), 32'd0);
    chk("r_err", 32'(err), 32'd0);
    chk("r_mvalid", 32'(bus.m_valid), 32'd0);
    next_cycle(); bus.m_rvalid = 1'b0;

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
